// File: rtl/multdiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_seq_pkg
//  Desc     : Shared state encoding, ALU opcodes and default widths for the
//             multiply/divide sequencer and its helpers.
//  Revision : 1.0  initial release
// ============================================================================
package multdiv_seq_pkg;

    localparam int DEF_WIDTH          = 32;
    localparam int DEF_TAG_W          = 5;
    localparam int DEF_CNT_W          = 8;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // ALU opcodes of the two operations handled by the shared unit
    localparam logic [4:0] MULT_OP = 5'b00110;
    localparam logic [4:0] DIV_OP  = 5'b00111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Mult has priority when both op flags are raised together
    function automatic logic [4:0] sel_op(input logic is_mult);
        return is_mult ? MULT_OP : DIV_OP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multdiv_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Desc     : Saturating up-counter. Clear loads the value 1 (the cycle in
//             which the clear happens is counted); increment stops at all-ones.
//             o_next exposes the value the counter takes on an increment.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_next
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_MAX = '1;

    logic [CNT_W-1:0] r_count;

    // Saturating successor of the current count
    always_comb begin
        o_next = (r_count == c_MAX) ? r_count : (r_count + c_ONE);
    end

    // Counter register: clear has priority over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= c_ONE;
        end else if (i_inc) begin
            r_count <= o_next;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_sequencer
//  Desc     : Controller between the execute stage and the shared iterative
//             multiply/divide unit. Latches a request, pulses the unit once,
//             stalls the pipeline until the unit is ready and presents the
//             captured result for one cycle.
//             Optional build macro MULTDIV_TIMEOUT_EN aborts a WAIT that
//             lasts TIMEOUT_CYCLES cycles without a ready from the unit.
//  Revision : 1.0  initial release
// ============================================================================
module multdiv_sequencer
    import multdiv_seq_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int TAG_W          = DEF_TAG_W,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_is_mult,
    input  logic             req_is_div,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             stall,
    output logic             busy,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_exception,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_timeout,
    output logic [CNT_W-1:0] last_cycles,
    output logic [WIDTH-1:0] mdu_a,
    output logic [WIDTH-1:0] mdu_b,
    output logic             mdu_ctrl_mult,
    output logic             mdu_ctrl_div,
    input  logic [WIDTH-1:0] mdu_result,
    input  logic             mdu_exception,
    input  logic             mdu_ready
);

    state_t           r_state;
    state_t           w_state_next;

    logic [4:0]       r_op;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] r_mdu_a;
    logic [WIDTH-1:0] r_mdu_b;
    logic [WIDTH-1:0] r_resp_result;
    logic             r_resp_exception;
    logic [TAG_W-1:0] r_resp_tag;
    logic [CNT_W-1:0] r_last_cycles;

    logic             w_req_ok;
    logic             w_accept;
    logic             w_capture;
    logic             w_abort;
    logic             w_timeout_hit;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_req_ok = req_valid & (req_is_mult | req_is_div);

    // One counter serves both the latency measurement and the timeout;
    // START loads 1 so the count covers START through the current WAIT cycle.
    sat_counter #(
        .CNT_W   (CNT_W)
    ) u_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_clear (r_state == ST_START),
        .i_inc   (r_state == ST_WAIT),
        .o_count (w_cnt),
        .o_next  (w_cnt_next)
    );

`ifdef MULTDIV_TIMEOUT_EN
    // During WAIT cycle k the counter holds k
    assign w_timeout_hit = (int'(w_cnt) >= TIMEOUT_CYCLES);
`else
    logic w_timeout_unused;
    assign w_timeout_unused = (TIMEOUT_CYCLES > 0);
    assign w_timeout_hit    = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and datapath strobes; a ready beats a same-cycle timeout
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_ok) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                // ready is ignored here: the unit may still show a stale one
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mdu_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_DONE;
                end else if (w_timeout_hit) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch and response capture registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_op             <= '0;
            r_tag            <= '0;
            r_mdu_a          <= '0;
            r_mdu_b          <= '0;
            r_resp_result    <= '0;
            r_resp_exception <= 1'b0;
            r_resp_tag       <= '0;
            r_last_cycles    <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= sel_op(req_is_mult);
                r_tag   <= req_tag;
                r_mdu_a <= req_a;
                r_mdu_b <= req_b;
            end
            if (w_capture) begin
                r_resp_result    <= mdu_result;
                r_resp_exception <= mdu_exception;
                r_resp_tag       <= r_tag;
                r_last_cycles    <= w_cnt_next;
            end else if (w_abort) begin
                r_resp_result    <= '0;
                r_resp_exception <= 1'b1;
                r_resp_tag       <= r_tag;
                r_last_cycles    <= w_cnt_next;
            end
        end
    end

`ifdef MULTDIV_TIMEOUT_EN
    logic r_resp_timeout;

    // Timeout flag follows each completion
    always_ff @(posedge clock) begin
        if (reset) begin
            r_resp_timeout <= 1'b0;
        end else if (w_capture) begin
            r_resp_timeout <= 1'b0;
        end else if (w_abort) begin
            r_resp_timeout <= 1'b1;
        end
    end

    assign resp_timeout = r_resp_timeout;
`else
    assign resp_timeout = 1'b0;
`endif

    // stall drops in DONE so the instruction retires on that edge
    assign stall          = ((r_state == ST_IDLE) & w_req_ok)
                          | (r_state == ST_START)
                          | (r_state == ST_WAIT);
    assign busy           = (r_state != ST_IDLE);
    assign resp_valid     = (r_state == ST_DONE);
    assign resp_result    = r_resp_result;
    assign resp_exception = r_resp_exception;
    assign resp_tag       = r_resp_tag;
    assign last_cycles    = r_last_cycles;
    assign mdu_a          = r_mdu_a;
    assign mdu_b          = r_mdu_b;
    assign mdu_ctrl_mult  = (r_state == ST_START) & (r_op == MULT_OP);
    assign mdu_ctrl_div   = (r_state == ST_START) & (r_op == DIV_OP);

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multdiv_sequencer
//  Desc     : Directed scoreboard bench for multdiv_sequencer. Stimulus pushes
//             hand-computed responses; a monitor pops them on resp_valid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multdiv_sequencer;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int CNT_W = 8;
`ifdef MULTDIV_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             req_valid, req_is_mult, req_is_div;
    logic [WIDTH-1:0] req_a, req_b;
    logic [TAG_W-1:0] req_tag;
    logic             stall, busy, resp_valid, resp_exception, resp_timeout;
    logic [WIDTH-1:0] resp_result, mdu_a, mdu_b, mdu_result;
    logic [TAG_W-1:0] resp_tag;
    logic [CNT_W-1:0] last_cycles;
    logic             mdu_ctrl_mult, mdu_ctrl_div, mdu_exception, mdu_ready;

    multdiv_sequencer #(
        .WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_is_mult(req_is_mult), .req_is_div(req_is_div),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .stall(stall), .busy(busy), .resp_valid(resp_valid),
        .resp_result(resp_result), .resp_exception(resp_exception),
        .resp_tag(resp_tag), .resp_timeout(resp_timeout), .last_cycles(last_cycles),
        .mdu_a(mdu_a), .mdu_b(mdu_b),
        .mdu_ctrl_mult(mdu_ctrl_mult), .mdu_ctrl_div(mdu_ctrl_div),
        .mdu_result(mdu_result), .mdu_exception(mdu_exception), .mdu_ready(mdu_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             exc;
        logic [TAG_W-1:0] tag;
        logic             tmo;
        logic [CNT_W-1:0] cycles;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_mult = 0, n_div = 0, n_stall = 0;
    int   last_resp_cyc = 0;
    int   accept_cyc = 0;
    int   pulse_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] r, input logic e, input logic [TAG_W-1:0] t,
                            input logic to, input logic [CNT_W-1:0] c);
        exp_t x;
        x.result = r; x.exc = e; x.tag = t; x.tmo = to; x.cycles = c;
        sb_q.push_back(x);
    endtask

    // Monitor: pulse/stall bookkeeping and scoreboard compare on resp_valid
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (mdu_ctrl_mult) n_mult++;
            if (mdu_ctrl_div)  n_div++;
            if (stall)         n_stall++;
            check("pulse_exclusive", 64'(mdu_ctrl_mult & mdu_ctrl_div), 64'd0);
            if (resp_valid) begin
                last_resp_cyc = cyc;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: actual=resp_valid result=%0h required=no response", resp_result);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_result",    64'(resp_result),    64'(e.result));
                    check("resp_exception", 64'(resp_exception), 64'(e.exc));
                    check("resp_tag",       64'(resp_tag),       64'(e.tag));
                    check("resp_timeout",   64'(resp_timeout),   64'(e.tmo));
                    check("last_cycles",    64'(last_cycles),    64'(e.cycles));
                    check("stall_in_done",  64'(stall),          64'd0);
                end
            end
        end
    end

    // Present a request in the next cycle and confirm it is accepted from IDLE
    task automatic issue(input logic m, input logic d, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
        @(posedge clock);
        #1;
        req_valid = 1'b1; req_is_mult = m; req_is_div = d;
        req_a = a; req_b = b; req_tag = t;
        accept_cyc = cyc;
        @(negedge clock);
        check("accept_stall", 64'(stall), 64'd1);
        check("accept_busy",  64'(busy),  64'd0);
    endtask

    // Wait (bounded) for the start pulse, then check operands and pulse kind
    task automatic wait_pulse(input logic exp_mult, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (mdu_ctrl_mult | mdu_ctrl_div) begin
                ok = 1;
                break;
            end
        end
        req_valid = 1'b0;
        pulse_cyc = cyc;
        check("pulse_seen",    64'(ok), 64'd1);
        check("pulse_kind",    64'(mdu_ctrl_mult), 64'(exp_mult));
        check("pulse_latency", 64'(pulse_cyc - accept_cyc), 64'd1);
        check("mdu_a",         64'(mdu_a), 64'(a));
        check("mdu_b",         64'(mdu_b), 64'(b));
    endtask

    // Raise ready in WAIT cycle k (k posedges after the pulse), for one cycle
    task automatic drive_ready(input int k, input logic [WIDTH-1:0] r, input logic e);
        repeat (k) @(posedge clock);
        #1;
        mdu_ready = 1'b1; mdu_result = r; mdu_exception = e;
        @(posedge clock);
        #1;
        mdu_ready = 1'b0; mdu_result = '0; mdu_exception = 1'b0;
    endtask

    // Bounded wait for the scoreboard to empty
    task automatic drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clock);
            #1;
        end
        check(name, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic check_zero_outputs();
        check("rst_stall",       64'(stall),          64'd0);
        check("rst_busy",        64'(busy),           64'd0);
        check("rst_resp_valid",  64'(resp_valid),     64'd0);
        check("rst_resp_result", 64'(resp_result),    64'd0);
        check("rst_resp_exc",    64'(resp_exception), 64'd0);
        check("rst_resp_tag",    64'(resp_tag),       64'd0);
        check("rst_resp_tmo",    64'(resp_timeout),   64'd0);
        check("rst_last_cycles", 64'(last_cycles),    64'd0);
        check("rst_mdu_a",       64'(mdu_a),          64'd0);
        check("rst_mdu_b",       64'(mdu_b),          64'd0);
        check("rst_ctrl_mult",   64'(mdu_ctrl_mult),  64'd0);
        check("rst_ctrl_div",    64'(mdu_ctrl_div),   64'd0);
    endtask

    initial begin
        int m0, d0, r1;
        reset = 1'b1;
        req_valid = 1'b0; req_is_mult = 1'b0; req_is_div = 1'b0;
        req_a = '0; req_b = '0; req_tag = '0;
        mdu_result = '0; mdu_exception = 1'b0; mdu_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_zero_outputs();
        @(posedge clock);
        #1 reset = 1'b0;

        // Ignored request: valid with neither op flag
        req_valid = 1'b1; req_a = 32'd1; req_b = 32'd1;
        @(negedge clock);
        check("noop_stall", 64'(stall), 64'd0);
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("noop_busy", 64'(busy), 64'd0);

        // 1) mult 7x6, ready 32 cycles after the pulse
        m0 = n_mult; d0 = n_div; n_stall = 0;
        push_exp(32'd42, 1'b0, 5'd5, 1'b0, 8'd33);
        issue(1'b1, 1'b0, 32'd7, 32'd6, 5'd5);
        wait_pulse(1'b1, 32'd7, 32'd6);
        drive_ready(32, 32'd42, 1'b0);
        drain("drain_mult7x6");
        @(posedge clock);
        #1;
        check("mult_stall_cycles", 64'(n_stall), 64'd34);
        check("mult_pulses", 64'(n_mult - m0), 64'd1);
        check("mult_no_div", 64'(n_div - d0),  64'd0);
        check("resp_hold_result", 64'(resp_result), 64'd42);

        // 2) div 100/0 with exception from the unit
        m0 = n_mult; d0 = n_div;
        push_exp(32'hFFFF_FFFF, 1'b1, 5'd9, 1'b0, 8'd4);
        issue(1'b0, 1'b1, 32'd100, 32'd0, 5'd9);
        wait_pulse(1'b0, 32'd100, 32'd0);
        drive_ready(3, 32'hFFFF_FFFF, 1'b1);
        drain("drain_div0");
        @(posedge clock);
        #1;
        check("div_pulses", 64'(n_div - d0),  64'd1);
        check("div_no_mult", 64'(n_mult - m0), 64'd0);

        // 3) Back-to-back mults 3x4 then 5x5; both flags on the second: mult wins
        m0 = n_mult;
        push_exp(32'd12, 1'b0, 5'd1, 1'b0, 8'd2);
        push_exp(32'd25, 1'b0, 5'd2, 1'b0, 8'd3);
        issue(1'b1, 1'b0, 32'd3, 32'd4, 5'd1);
        wait_pulse(1'b1, 32'd3, 32'd4);
        drive_ready(1, 32'd12, 1'b0);
        r1 = accept_cyc;
        issue(1'b1, 1'b1, 32'd5, 32'd5, 5'd2);
        check("min_latency", 64'(last_resp_cyc - r1), 64'd3);
        wait_pulse(1'b1, 32'd5, 32'd5);
        check("one_idle_gap", 64'(pulse_cyc - last_resp_cyc), 64'd2);
        drive_ready(2, 32'd25, 1'b0);
        drain("drain_b2b");
        @(posedge clock);
        #1;
        check("b2b_pulses", 64'(n_mult - m0), 64'd2);

        // 4) Stale ready during START, low for 5 WAIT cycles
        push_exp(32'd81, 1'b0, 5'd3, 1'b0, 8'd7);
        mdu_ready = 1'b1; mdu_result = 32'hDEAD_BEEF;
        issue(1'b1, 1'b0, 32'd9, 32'd9, 5'd3);
        wait_pulse(1'b1, 32'd9, 32'd9);
        @(posedge clock);
        #1 mdu_ready = 1'b0; mdu_result = '0;
        drive_ready(5, 32'd81, 1'b0);
        drain("drain_stale");

        // 5) Reset in the middle of WAIT: no response, everything cleared
        m0 = n_mult;
        issue(1'b1, 1'b0, 32'd2, 32'd2, 5'd7);
        wait_pulse(1'b1, 32'd2, 32'd2);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_zero_outputs();
        @(posedge clock);
        #1 mdu_ready = 1'b1; mdu_result = 32'd4;
        repeat (3) @(posedge clock);
        #1 mdu_ready = 1'b0; mdu_result = '0;
        @(negedge clock);
        check("rst_abort_busy",   64'(busy), 64'd0);
        check("rst_abort_pulses", 64'(n_mult - m0), 64'd1);

`ifdef MULTDIV_TIMEOUT_EN
        // 6) Timeout after TMO WAIT cycles with ready never asserted
        push_exp(32'd0, 1'b1, 5'd11, 1'b1, 8'd9);
        issue(1'b1, 1'b0, 32'd6, 32'd7, 5'd11);
        wait_pulse(1'b1, 32'd6, 32'd7);
        drain("drain_timeout");
        check("timeout_latency", 64'(last_resp_cyc - pulse_cyc), 64'(TMO + 1));
`endif

        repeat (4) @(posedge clock);
        check("final_queue_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
